iir_filter: RTL and testbench

//  Parametrised direct-form-I IIR filter, fixed-point Qx.FRAC_BITS, FIFO-style streaming in/out.

---
 rtl/iir_pkg.sv | 63 ++++++
 rtl/iir_mac.sv | 59 +++++
 rtl/iir_filter.sv | 187 ++++++++++++++++++
 tb/tb_iir_filter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iir_pkg
//  Purpose  : Shared types and arithmetic helpers for the iir_filter block.
//             Holds the FSM state encoding, the accumulator width helper,
//             and the fixed-point dequantise / saturate functions.
//  Contents : state_t, WIDE_WIDTH, acc_width(), dequantize(), saturate()
//  Revision : 1.0  initial release
// ============================================================================
package iir_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_MAC   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    // The helpers work on one fixed wide signed type so they can serve any
    // instance width up to DATA_WIDTH = 63. Callers sign-extend in and
    // size-cast the result back down.
    localparam int WIDE_WIDTH = 128;

    // Accumulator needs headroom for 2N+1 DATA_WIDTH-wide terms.
    function automatic int acc_width(input int dw, input int order);
        return dw + $clog2(2 * order + 1);
    endfunction

    // Arithmetic right shift by frac_bits, rounding toward zero. Negative
    // values get a bias of 2^frac_bits-1 first so the floor behaviour of
    // >>> becomes truncation toward zero.
    function automatic logic signed [WIDE_WIDTH-1:0] dequantize(
        input logic signed [WIDE_WIDTH-1:0] p,
        input int                           frac_bits
    );
        logic signed [WIDE_WIDTH-1:0] bias;
        bias = (128'sd1 <<< frac_bits) - 128'sd1;
        if (p < 0) begin
            return (p + bias) >>> frac_bits;
        end
        return p >>> frac_bits;
    endfunction

    // Clamp to the signed range of a dw-bit two's complement number.
    function automatic logic signed [WIDE_WIDTH-1:0] saturate(
        input logic signed [WIDE_WIDTH-1:0] v,
        input int                           dw
    );
        logic signed [WIDE_WIDTH-1:0] hi;
        logic signed [WIDE_WIDTH-1:0] lo;
        hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage : iir_pkg
`default_nettype wire

// File: rtl/iir_mac.sv
`default_nettype none
// ============================================================================
//  Module   : iir_mac
//  Purpose  : Single time-multiplexed signed multiply, dequantise and
//             accumulate stage for the IIR filter.
//  Ports    : clock     in  rising-edge clock
//             reset     in  synchronous active-low reset
//             clear     in  zero the accumulator (wins over enable)
//             enable    in  add DEQ(sample*coeff) into the accumulator
//             sample    in  signed DATA_WIDTH operand
//             coeff     in  signed DATA_WIDTH coefficient
//             acc_next  out accumulator value including this cycle's term
//  Revision : 1.0  initial release
// ============================================================================
module iir_mac
    import iir_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    parameter int ACC_WIDTH  = 34
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic signed [DATA_WIDTH-1:0] coeff,
    output logic signed [ACC_WIDTH-1:0]  acc_next
);

    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [WIDE_WIDTH-1:0]   product_wide;
    logic signed [DATA_WIDTH-1:0]   deq;

    // Operands are extended explicitly so the full-precision product is
    // formed at 2*DATA_WIDTH bits.
    assign product = {{DATA_WIDTH{sample[DATA_WIDTH-1]}}, sample}
                   * {{DATA_WIDTH{coeff[DATA_WIDTH-1]}}, coeff};

    assign product_wide = {{(WIDE_WIDTH-2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};

    // Each dequantised term is truncated to DATA_WIDTH before accumulation.
    assign deq = DATA_WIDTH'(dequantize(product_wide, FRAC_BITS));

    assign acc_next = acc + {{(ACC_WIDTH-DATA_WIDTH){deq[DATA_WIDTH-1]}}, deq};

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc_next;
        end
    end

endmodule : iir_mac
`default_nettype wire

// File: rtl/iir_filter.sv
`default_nettype none
// ============================================================================
//  Module   : iir_filter
//  Purpose  : Direct-form-I IIR filter with decimation, FIFO-style streaming
//             input/output and a single shared multiplier. Computes
//             y[n] = SAT( sum DEQ(b_k*x[n-k]) + sum DEQ(a_k*y[n-k]) ).
//  Ports    : clock        in   rising-edge clock
//             reset        in   synchronous active-low reset
//             x_in         in   input sample, valid when x_in_empty=0
//             x_in_rd_en   out  pop input FIFO this cycle
//             x_in_empty   in   input FIFO empty
//             y_out        out  registered output sample
//             y_out_wr_en  out  push y_out into output FIFO this cycle
//             y_out_full   in   output FIFO full
//  Revision : 1.0  initial release
// ============================================================================
module iir_filter
    import iir_pkg::*;
#(
    parameter int                          DATA_WIDTH = 32,
    parameter int                          FRAC_BITS  = 10,
    parameter int                          ORDER      = 1,
    parameter int                          DECIMATION = 1,
    parameter logic signed [DATA_WIDTH-1:0] B_COEFFS [0:ORDER] = '{178, 178},
    parameter logic signed [DATA_WIDTH-1:0] A_COEFFS [1:ORDER] = '{666}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] x_in,
    output logic                  x_in_rd_en,
    input  logic                  x_in_empty,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  y_out_wr_en,
    input  logic                  y_out_full
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, ORDER);
    localparam int NTAPS     = 2 * ORDER + 1;
    localparam int CNT_MAX   = (DECIMATION > NTAPS) ? DECIMATION : NTAPS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    state_t                        state;
    state_t                        state_nxt;
    logic [CNT_W-1:0]              count;
    logic signed [DATA_WIDTH-1:0]  x_hist [0:ORDER];
    logic signed [DATA_WIDTH-1:0]  y_hist [1:ORDER];

    logic                          mac_clear;
    logic                          mac_en;
    logic signed [DATA_WIDTH-1:0]  tap_sample;
    logic signed [DATA_WIDTH-1:0]  tap_coeff;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [WIDE_WIDTH-1:0]  acc_wide;

    logic                          last_pop;
    logic                          last_tap;

    assign last_pop = (count == CNT_W'(DECIMATION - 1));
    assign last_tap = (count == CNT_W'(NTAPS - 1));

    // Tap schedule: indices 0..N walk the x history with b coefficients,
    // indices N+1..2N walk the y history with a coefficients.
    always_comb begin
        tap_sample = '0;
        tap_coeff  = '0;
        for (int k = 0; k <= ORDER; k++) begin
            if (count == CNT_W'(k)) begin
                tap_sample = x_hist[k];
                tap_coeff  = B_COEFFS[k];
            end
        end
        for (int k = 1; k <= ORDER; k++) begin
            if (count == CNT_W'(ORDER + k)) begin
                tap_sample = y_hist[k];
                tap_coeff  = A_COEFFS[k];
            end
        end
    end

    iir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clock    (clock),
        .reset    (reset),
        .clear    (mac_clear),
        .enable   (mac_en),
        .sample   (tap_sample),
        .coeff    (tap_coeff),
        .acc_next (acc_next)
    );

    assign acc_wide = {{(WIDE_WIDTH-ACC_WIDTH){acc_next[ACC_WIDTH-1]}}, acc_next};

    // Next-state and handshake outputs. The FIFO strobes are combinational
    // so a pop/push lands in the same cycle the FIFO flag allows it.
    always_comb begin
        state_nxt   = state;
        x_in_rd_en  = 1'b0;
        y_out_wr_en = 1'b0;
        mac_clear   = 1'b0;
        mac_en      = 1'b0;
        case (state)
            S_IDLE: begin
                mac_clear = 1'b1;
                state_nxt = S_READ;
            end
            S_READ: begin
                if (!x_in_empty) begin
                    x_in_rd_en = 1'b1;
                    if (last_pop) begin
                        state_nxt = S_MAC;
                    end
                end
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (last_tap) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!y_out_full) begin
                    y_out_wr_en = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
            count <= '0;
            y_out <= '0;
            for (int k = 0; k <= ORDER; k++) begin
                x_hist[k] <= '0;
            end
            for (int k = 1; k <= ORDER; k++) begin
                y_hist[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    count <= '0;
                end
                S_READ: begin
                    if (x_in_rd_en) begin
                        for (int k = ORDER; k >= 1; k--) begin
                            x_hist[k] <= x_hist[k-1];
                        end
                        x_hist[0] <= x_in;
                        count     <= last_pop ? '0 : count + CNT_W'(1);
                    end
                end
                S_MAC: begin
                    if (last_tap) begin
                        // The final term is folded in combinationally so the
                        // new y[n] is registered on the last MAC cycle.
                        y_out <= DATA_WIDTH'(saturate(acc_wide, DATA_WIDTH));
                        count <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    if (y_out_wr_en) begin
                        for (int k = ORDER; k >= 2; k--) begin
                            y_hist[k] <= y_hist[k-1];
                        end
                        y_hist[1] <= y_out;
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

endmodule : iir_filter
`default_nettype wire

// File: tb/tb_iir_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iir_filter
//  Purpose  : Self-checking bench for iir_filter. Four instances cover the
//             impulse response, round-toward-zero, saturation and
//             decimation; hand sequences cover backpressure and reset
//             in the middle of a computation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iir_filter;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] x_in    [4];
    logic          x_empty [4];
    logic          y_full  [4];
    logic          rd_en   [4];
    logic          wr_en   [4];
    logic [DW-1:0] y_out   [4];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int proto_err = 0;
    int rd_cnt [4] = '{0, 0, 0, 0};
    int wr_cnt [4] = '{0, 0, 0, 0};

    always #5 clock = ~clock;

    // 0: impulse-response filter
    iir_filter #(.DATA_WIDTH(DW), .FRAC_BITS(10), .ORDER(1), .DECIMATION(1),
                 .B_COEFFS('{178, 178}), .A_COEFFS('{666})) u_imp (
        .clock(clock), .reset(reset), .x_in(x_in[0]), .x_in_rd_en(rd_en[0]),
        .x_in_empty(x_empty[0]), .y_out(y_out[0]), .y_out_wr_en(wr_en[0]),
        .y_out_full(y_full[0]));

    // 1: rounding
    iir_filter #(.DATA_WIDTH(DW), .FRAC_BITS(10), .ORDER(1), .DECIMATION(1),
                 .B_COEFFS('{1, 0}), .A_COEFFS('{0})) u_rnd (
        .clock(clock), .reset(reset), .x_in(x_in[1]), .x_in_rd_en(rd_en[1]),
        .x_in_empty(x_empty[1]), .y_out(y_out[1]), .y_out_wr_en(wr_en[1]),
        .y_out_full(y_full[1]));

    // 2: saturation
    iir_filter #(.DATA_WIDTH(DW), .FRAC_BITS(10), .ORDER(1), .DECIMATION(1),
                 .B_COEFFS('{1024, 1024}), .A_COEFFS('{0})) u_sat (
        .clock(clock), .reset(reset), .x_in(x_in[2]), .x_in_rd_en(rd_en[2]),
        .x_in_empty(x_empty[2]), .y_out(y_out[2]), .y_out_wr_en(wr_en[2]),
        .y_out_full(y_full[2]));

    // 3: decimate by two
    iir_filter #(.DATA_WIDTH(DW), .FRAC_BITS(10), .ORDER(1), .DECIMATION(2),
                 .B_COEFFS('{1024, 512}), .A_COEFFS('{0})) u_dec (
        .clock(clock), .reset(reset), .x_in(x_in[3]), .x_in_rd_en(rd_en[3]),
        .x_in_empty(x_empty[3]), .y_out(y_out[3]), .y_out_wr_en(wr_en[3]),
        .y_out_full(y_full[3]));

    // Handshake monitor, sampled mid-cycle after the bench's drives settle.
    always begin
        @(negedge clock);
        #3;
        for (int d = 0; d < 4; d++) begin
            if (rd_en[d] && x_empty[d]) proto_err++;
            if (wr_en[d] && y_full[d])  proto_err++;
            if (rd_en[d] && wr_en[d])   proto_err++;
            if (rd_en[d]) rd_cnt[d]++;
            if (wr_en[d]) wr_cnt[d]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one sample until the DUT pops it. Entered and left on a negedge.
    task automatic feed(input int d, input logic [DW-1:0] x);
        bit got = 1'b0;
        x_in[d]    = x;
        x_empty[d] = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            #1;
            if (rd_en[d]) got = 1'b1;
            @(negedge clock);
        end
        x_empty[d] = 1'b1;
        if (!got) begin
            total_cnt++;
            $display("FAIL feed_timeout dut%0d: got no rd_en expected rd_en", d);
        end
    endtask

    // Wait for a push and compare the pushed value.
    task automatic collect(input int d, input logic [DW-1:0] exp, input string name);
        bit            got = 1'b0;
        logic [DW-1:0] y   = '0;
        for (int i = 0; i < 60 && !got; i++) begin
            #1;
            if (wr_en[d]) begin
                got = 1'b1;
                y   = y_out[d];
            end
            @(negedge clock);
        end
        if (got) begin
            check(name, y, exp);
        end else begin
            total_cnt++;
            $display("FAIL %s: got no wr_en expected %h", name, exp);
        end
    endtask

    typedef struct {
        int            d;
        int            n;
        logic [DW-1:0] x0;
        logic [DW-1:0] x1;
        logic [DW-1:0] y;
        string         name;
    } vec_t;

    task automatic apply_vec(input vec_t v);
        int snap;
        snap = rd_cnt[v.d];
        feed(v.d, v.x0);
        if (v.n == 2) feed(v.d, v.x1);
        collect(v.d, v.y, v.name);
        if (v.d == 3) check({v.name, "_rd_pulses"}, DW'(rd_cnt[v.d] - snap), 32'd2);
    endtask

    initial begin
        vec_t vecs[$];
        int   wc;
        bit   hold_ok;

        vecs.push_back('{0, 1, 32'd1024, 32'd0, 32'd178, "imp_y0"});
        vecs.push_back('{0, 1, 32'd0,    32'd0, 32'd293, "imp_y1"});
        vecs.push_back('{0, 1, 32'd0,    32'd0, 32'd190, "imp_y2"});
        vecs.push_back('{1, 1, 32'hFFFF_FFFF, 32'd0, 32'd0,        "rnd_m1"});
        vecs.push_back('{1, 1, 32'hFFFF_FC00, 32'd0, 32'hFFFF_FFFF, "rnd_m1024"});
        vecs.push_back('{1, 1, 32'd1025,      32'd0, 32'd1,        "rnd_p1025"});
        vecs.push_back('{1, 1, 32'hFFFF_F801, 32'd0, 32'hFFFF_FFFF, "rnd_m2047"});
        vecs.push_back('{1, 1, 32'hFFFF_F800, 32'd0, 32'hFFFF_FFFE, "rnd_m2048"});
        vecs.push_back('{2, 1, 32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, "sat_max_first"});
        vecs.push_back('{2, 1, 32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, "sat_pos_clamp"});
        vecs.push_back('{2, 1, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, "sat_mixed"});
        vecs.push_back('{2, 1, 32'h8000_0000, 32'd0, 32'h8000_0000, "sat_neg_clamp"});
        vecs.push_back('{2, 1, 32'd0,         32'd0, 32'h8000_0000, "sat_min_exact"});
        vecs.push_back('{2, 1, 32'hFFFF_FC00, 32'd0, 32'hFFFF_FC00, "sat_m1024"});
        vecs.push_back('{2, 1, 32'd0,         32'd0, 32'hFFFF_FC00, "sat_hist"});
        vecs.push_back('{3, 2, 32'd1024, 32'd2048,      32'd2560, "dec_a"});
        vecs.push_back('{3, 2, 32'd4096, 32'hFFFF_FC00, 32'd1024, "dec_b"});

        for (int d = 0; d < 4; d++) begin
            x_in[d]    = '0;
            x_empty[d] = 1'b1;
            y_full[d]  = 1'b0;
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset_y_out%0d", d), y_out[d], 32'd0);
        end
        check("reset_strobes", {30'd0, wr_en[0], rd_en[0]}, 32'd0);
        @(negedge clock);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Backpressure: new y = DEQ(666*190) = 123, held while full.
        y_full[0] = 1'b1;
        feed(0, 32'd0);
        repeat (8) @(negedge clock);
        wc      = wr_cnt[0];
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (wr_en[0] || y_out[0] !== 32'd123) hold_ok = 1'b0;
            @(negedge clock);
        end
        check("bp_hold_stable", {31'd0, hold_ok}, 32'd1);
        check("bp_no_push_while_full", DW'(wr_cnt[0] - wc), 32'd0);
        y_full[0] = 1'b0;
        collect(0, 32'd123, "bp_release");
        repeat (10) @(negedge clock);
        check("bp_single_push", DW'(wr_cnt[0] - wc), 32'd1);

        // Reset in the middle of MAC discards the computation.
        feed(0, 32'd1024);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_mid_y_cleared", y_out[0], 32'd0);
        wc = wr_cnt[0];
        repeat (10) @(negedge clock);
        check("rst_mid_no_push", DW'(wr_cnt[0] - wc), 32'd0);
        for (int i = 0; i < 3; i++) apply_vec(vecs[i]);

        check("protocol_violations", DW'(proto_err), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_iir_filter
`default_nettype wire
